// File: rtl/lsu_postinc.sv
// Multi-cycle load/store unit with post-increment addressing. Runs a req/gnt + rvalid
// handshake with data memory and returns the load result and the rs1+imm write-back.
module lsu_postinc #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ls_valid,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic            post_inc,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    output logic            stall,
    output logic            rf_en,
    output logic [XLEN-1:0] wdata,
    output logic            post_inc_en,
    output logic [XLEN-1:0] post_inc_data,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            exc_misalign,
    output logic            exc_bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_store;
    logic            r_pmode;
    logic [2:0]      r_f3;
    logic [4:0]      r_rs1a;
    logic [4:0]      r_rda;
    logic [XLEN-1:0] r_ea;
    logic [XLEN-1:0] r_pinc;
    logic [XLEN-1:0] r_sdata;
    logic [XLEN-1:0] r_wdata;
    logic [CW-1:0]   r_cnt;
    logic            r_exc_mis;
    logic            r_exc_bus;

    logic [XLEN-1:0] w_pinc;
    logic [XLEN-1:0] w_ea;
    logic            w_mis;
    logic [CW-1:0]   w_cnt_next;
    logic            w_tmo;

    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                    input logic [1:0]      ofs,
                                                    input logic [2:0]      f3);
        logic [XLEN-1:0] sh;
        logic            sgn;
        sh  = word >> {ofs, 3'b000};
        sgn = 1'b0;
        case (f3[1:0])
            2'b00: begin
                sgn = sh[7] & ~f3[2];
                load_extend = {{(XLEN-8){sgn}}, sh[7:0]};
            end
            2'b01: begin
                sgn = sh[15] & ~f3[2];
                load_extend = {{(XLEN-16){sgn}}, sh[15:0]};
            end
            default: load_extend = word;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_lanes(input logic [XLEN-1:0] d,
                                                    input logic [2:0]      f3);
        case (f3[1:0])
            2'b00:   store_lanes = {(XLEN/8){d[7:0]}};
            2'b01:   store_lanes = {(XLEN/16){d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] ofs);
        case (f3[1:0])
            2'b00:   store_strb = 4'b0001 << ofs;
            2'b01:   store_strb = 4'b0011 << ofs;
            default: store_strb = 4'b1111;
        endcase
    endfunction

    // Post-increment mode addresses with the unmodified base; rs1+imm is only written back.
    assign w_pinc     = rs1_data + imm;
    assign w_ea       = post_inc ? rs1_data : w_pinc;
    assign w_mis      = ((funct3[1:0] == 2'b01) && w_ea[0]) ||
                        (funct3[1] && (w_ea[1:0] != 2'b00));
    assign w_cnt_next = r_cnt + 1'b1;
    assign w_tmo      = (w_cnt_next == CW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (ls_valid && !w_mis) w_next = REQ;
            REQ: begin
                if (mem_gnt)    w_next = r_store ? DONE : WAIT_R;
                else if (w_tmo) w_next = IDLE;
            end
            WAIT_R: begin
                if (mem_rvalid) w_next = DONE;
                else if (w_tmo) w_next = IDLE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_store   <= 1'b0;
            r_pmode   <= 1'b0;
            r_f3      <= '0;
            r_rs1a    <= '0;
            r_rda     <= '0;
            r_ea      <= '0;
            r_pinc    <= '0;
            r_sdata   <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_exc_mis <= 1'b0;
            r_exc_bus <= 1'b0;
        end else begin
            r_exc_mis <= (r_state == IDLE) && ls_valid && w_mis;
            r_exc_bus <= (((r_state == REQ) && !mem_gnt) ||
                          ((r_state == WAIT_R) && !mem_rvalid)) && w_tmo;
            if ((r_state == IDLE) && ls_valid) begin
                r_store <= is_store;
                r_pmode <= post_inc;
                r_f3    <= funct3;
                r_rs1a  <= rs1_addr;
                r_rda   <= rd_addr;
                r_ea    <= w_ea;
                r_pinc  <= w_pinc;
                r_sdata <= rs2_data;
            end
            // The counter spans REQ and WAIT_R together and restarts from IDLE.
            if ((r_state == REQ) || (r_state == WAIT_R)) begin
                r_cnt <= w_cnt_next;
            end else begin
                r_cnt <= '0;
            end
            if ((r_state == WAIT_R) && mem_rvalid) begin
                r_wdata <= load_extend(mem_rdata, r_ea[1:0], r_f3);
            end
        end
    end

    always_comb begin
        stall       = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrb   = 4'b0000;
        rf_en       = 1'b0;
        post_inc_en = 1'b0;
        case (r_state)
            IDLE: stall = ls_valid;
            REQ: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_we   = r_store;
                mem_addr = {r_ea[XLEN-1:2], 2'b00};
                if (r_store) begin
                    mem_wdata = store_lanes(r_sdata, r_f3);
                    mem_wstrb = store_strb(r_f3, r_ea[1:0]);
                end
            end
            WAIT_R: stall = 1'b1;
            DONE: begin
                rf_en       = !r_store && (r_rda != 5'd0);
                // A load that targets its own base register keeps the load data.
                post_inc_en = r_pmode && (r_rs1a != 5'd0) && !(!r_store && (r_rda == r_rs1a));
            end
            default: ;
        endcase
    end

    assign wdata         = r_wdata;
    assign post_inc_data = r_pinc;
    assign exc_misalign  = r_exc_mis;
    assign exc_bus       = r_exc_bus;

endmodule
